// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU operation/word types plus the ALU arbiter state, request
// vector and requester count.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SLT = 4'd7
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef logic [1:0] req_vec_t;

    localparam int ARB_REQS = 2;
    // Wide enough for MAX_WAIT up to 15.
    localparam int STARVE_W = 4;

endpackage

// File: rtl/alu_arb_grant.sv
// Combinational one-hot grant selection for the two ALU requesters.
// ALU_ARB_RR_EN selects round-robin; otherwise fixed priority with a starvation guard.
module alu_arb_grant
    import cpu_types_pkg::*;
`ifndef ALU_ARB_RR_EN
#(
    parameter int MAX_WAIT = 4
)
`endif
(
    input  req_vec_t              req_valid,
`ifdef ALU_ARB_RR_EN
    input  logic                  rr_ptr,
`else
    input  logic [STARVE_W-1:0]   starve_cnt,
`endif
    output req_vec_t              grant
);

    always_comb begin
        grant = '0;
        if (req_valid == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            grant = rr_ptr ? 2'b10 : 2'b01;
`else
            // req1 is only forced through once it has been passed over MAX_WAIT times.
            grant = (starve_cnt == STARVE_W'(MAX_WAIT)) ? 2'b10 : 2'b01;
`endif
        end else begin
            grant = req_valid;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: grant, register operands, capture the
// result one cycle later and return it over a valid/ready response.
// Optional macro ALU_ARB_RR_EN switches the grant policy to round-robin.
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_WAIT = 4
)
(
    input  logic        CLK,
    input  logic        nRST,
    input  req_vec_t    req_valid,
    output req_vec_t    req_ready,
    input  aluop_t      req_op0,
    input  aluop_t      req_op1,
    input  word_t       req_a0,
    input  word_t       req_a1,
    input  word_t       req_b0,
    input  word_t       req_b1,
    output req_vec_t    rsp_valid,
    input  req_vec_t    rsp_ready,
    output word_t       rsp_out,
    output logic [2:0]  rsp_flags,
    output aluop_t      alu_op,
    output word_t       alu_a,
    output word_t       alu_b,
    input  word_t       alu_out,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_negative,
    output logic        busy
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("alu_arbiter: MAX_WAIT must be in 1..15");
    end

    arb_state_t state_reg;
    logic       owner_reg;
    req_vec_t   grant;

`ifdef ALU_ARB_RR_EN
    logic rr_ptr_reg;

    alu_arb_grant u_grant (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_reg),
        .grant     (grant)
    );
`else
    logic [STARVE_W-1:0] starve_cnt_reg;

    alu_arb_grant #(.MAX_WAIT(MAX_WAIT)) u_grant (
        .req_valid  (req_valid),
        .starve_cnt (starve_cnt_reg),
        .grant      (grant)
    );
`endif

    assign req_ready = (state_reg == IDLE) ? grant : '0;
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            rsp_valid      <= '0;
            rsp_out        <= '0;
            rsp_flags      <= '0;
            alu_op         <= ALU_ADD;
            alu_a          <= '0;
            alu_b          <= '0;
`ifdef ALU_ARB_RR_EN
            rr_ptr_reg     <= 1'b0;
`else
            starve_cnt_reg <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant != '0) begin
                        owner_reg <= grant[1];
                        alu_op    <= grant[1] ? req_op1 : req_op0;
                        alu_a     <= grant[1] ? req_a1  : req_a0;
                        alu_b     <= grant[1] ? req_b1  : req_b0;
                        state_reg <= EXEC;
`ifdef ALU_ARB_RR_EN
                        // Prefer whichever requester did not just win.
                        rr_ptr_reg <= grant[0];
`else
                        if (grant[1]) begin
                            starve_cnt_reg <= '0;
                        end else if (req_valid == 2'b11 &&
                                     starve_cnt_reg != STARVE_W'(MAX_WAIT)) begin
                            starve_cnt_reg <= starve_cnt_reg + 1'b1;
                        end
`endif
                    end
                end
                EXEC: begin
                    rsp_out   <= alu_out;
                    rsp_flags <= {alu_negative, alu_overflow, alu_zero};
                    rsp_valid <= owner_reg ? 2'b10 : 2'b01;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU drives the ALU port, a
// monitor predicts grants and checks every response against queued expectations.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    localparam int MAX_WAIT = 4;

    logic       CLK = 1'b0;
    logic       nRST;
    req_vec_t   req_valid, req_ready, rsp_valid, rsp_ready;
    aluop_t     req_op0, req_op1, alu_op;
    word_t      req_a0, req_a1, req_b0, req_b1;
    word_t      rsp_out, alu_a, alu_b, alu_out;
    logic [2:0] rsp_flags;
    logic       alu_zero, alu_overflow, alu_negative, busy;

    alu_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op0      (req_op0),
        .req_op1      (req_op1),
        .req_a0       (req_a0),
        .req_a1       (req_a1),
        .req_b0       (req_b0),
        .req_b1       (req_b1),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_out      (rsp_out),
        .rsp_flags    (rsp_flags),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .alu_negative (alu_negative),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    // Returns {negative, overflow, zero, result}.
    function automatic logic [34:0] alu_model(aluop_t op, word_t a, word_t b);
        word_t r;
        logic  ovf;
        ovf = 1'b0;
        case (op)
            ALU_ADD: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLL: r = a << b[4:0];
            ALU_SRL: r = a >> b[4:0];
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {r[31], ovf, (r == 32'd0), r};
    endfunction

    always_comb {alu_negative, alu_overflow, alu_zero, alu_out} = alu_model(alu_op, alu_a, alu_b);

    typedef struct packed {
        logic       req;
        word_t      out;
        logic [2:0] flags;
    } exp_t;

    exp_t sb[$];
    logic grant_log[$];
    int   checks = 0;
    int   errors = 0;

    // Reference arbitration state.
    int   waits = 0;
    logic pref = 1'b0;
    logic in_flight = 1'b0;
    int   lat = 0;
    logic rsp_seen = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    function automatic req_vec_t model_grant(req_vec_t v);
        if (v == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            return pref ? 2'b10 : 2'b01;
`else
            return (waits >= MAX_WAIT) ? 2'b10 : 2'b01;
`endif
        end
        return v;
    endfunction

    req_vec_t    mon_g;
    exp_t        mon_e;
    logic [34:0] mon_m;

    always @(negedge CLK) begin
        if (!nRST) begin
            sb.delete();
            in_flight = 1'b0;
            waits     = 0;
            pref      = 1'b0;
            lat       = 0;
        end else begin
            check("busy", busy, in_flight);
            mon_g = in_flight ? 2'b00 : model_grant(req_valid);
            check("req_ready", req_ready, mon_g);

            if (rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 2'b00);
                end else begin
                    mon_e = sb[0];
                    if (!rsp_seen) check("rsp_latency", lat, 1);
                    rsp_seen = 1'b1;
                    check("rsp_valid", rsp_valid, mon_e.req ? 2'b10 : 2'b01);
                    check("rsp_out", rsp_out, mon_e.out);
                    check("rsp_flags", rsp_flags, mon_e.flags);
                    if (rsp_ready[mon_e.req]) begin
                        void'(sb.pop_front());
                        in_flight = 1'b0;
                    end
                end
            end else if (in_flight) begin
                lat++;
                if (lat == 2) check("rsp_latency", lat, 1);
            end

            if (mon_g != 2'b00) begin
                mon_m = mon_g[1] ? alu_model(req_op1, req_a1, req_b1)
                                 : alu_model(req_op0, req_a0, req_b0);
                sb.push_back('{req: mon_g[1], out: mon_m[31:0], flags: mon_m[34:32]});
                grant_log.push_back(mon_g[1]);
                $display("grant req%0d op=%0d result=%08h flags=%03b",
                         mon_g[1], mon_g[1] ? req_op1 : req_op0, mon_m[31:0], mon_m[34:32]);
                in_flight = 1'b1;
                lat       = 0;
                rsp_seen  = 1'b0;
                if (mon_g[1]) waits = 0;
                else if (req_valid == 2'b11 && waits < MAX_WAIT) waits++;
                pref = mon_g[0];
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        check({tag, "_req_ready"}, req_ready, 2'b00);
        check({tag, "_rsp_valid"}, rsp_valid, 2'b00);
        check({tag, "_rsp_out"},   rsp_out, 32'd0);
        check({tag, "_rsp_flags"}, rsp_flags, 3'd0);
        check({tag, "_alu_op"},    alu_op, ALU_ADD);
        check({tag, "_alu_a"},     alu_a, 32'd0);
        check({tag, "_alu_b"},     alu_b, 32'd0);
        check({tag, "_busy"},      busy, 1'b0);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLK);
            if (!busy && sb.size() == 0) done = 1'b1;
        end
        if (!done) check("idle_timeout", busy, 1'b0);
    endtask

    task automatic issue(logic r, aluop_t op, word_t a, word_t b);
        @(posedge CLK); #1;
        rsp_ready = 2'b11;
        if (r) begin req_op1 = op; req_a1 = a; req_b1 = b; req_valid = 2'b10; end
        else   begin req_op0 = op; req_a0 = a; req_b0 = b; req_valid = 2'b01; end
        @(posedge CLK); #1;
        req_valid = 2'b00;
        wait_idle();
    endtask

    task automatic randomize_operands();
        req_op0 = aluop_t'($urandom_range(0, 7));
        req_op1 = aluop_t'($urandom_range(0, 7));
        req_a0  = $urandom;
        req_a1  = $urandom;
        req_b0  = ($urandom_range(0, 3) == 0) ? req_a0 : $urandom;
        req_b1  = $urandom;
    endtask

    task automatic pulse_reset();
        @(posedge CLK); #1;
        nRST = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        req_op0 = ALU_ADD; req_op1 = ALU_ADD;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // Single request, flags, and results returned only to requester 1.
        issue(1'b0, ALU_ADD, 32'd5, 32'd7);
        issue(1'b1, ALU_SUB, 32'd3, 32'd3);
        issue(1'b1, ALU_SUB, 32'd0, 32'd1);
        issue(1'b0, ALU_ADD, 32'h7fff_ffff, 32'd1);

        // Response backpressure with both requesters valid.
        @(posedge CLK); #1;
        randomize_operands();
        req_valid = 2'b11; rsp_ready = 2'b00;
        repeat (8) @(posedge CLK);
        #1 rsp_ready = 2'b11;
        @(posedge CLK); #1 req_valid = 2'b00;
        wait_idle();

        // Continuous contention: grant order from a clean reset.
        pulse_reset();
        grant_log.delete();
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int i = 0; i < 200 && grant_log.size() < 10; i++) begin
            randomize_operands();
            @(posedge CLK); #1;
        end
        req_valid = 2'b00;
        wait_idle();
        check("grant_count", grant_log.size() >= 10, 1'b1);
        for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
`ifdef ALU_ARB_RR_EN
            check($sformatf("grant_order%0d", i), grant_log[i], (i % 2) == 1);
`else
            check($sformatf("grant_order%0d", i), grant_log[i], (i % 5) == 4);
`endif
        end

        // Lone req1 wins every transaction.
        grant_log.delete();
        req_valid = 2'b10;
        for (int i = 0; i < 100 && grant_log.size() < 4; i++) begin
            randomize_operands();
            @(posedge CLK); #1;
        end
        req_valid = 2'b00;
        wait_idle();
        check("lone_req1_count", grant_log.size() >= 4, 1'b1);
        foreach (grant_log[i]) check($sformatf("lone_req1_%0d", i), grant_log[i], 1'b1);

        // Reset during EXEC discards the operation.
        @(posedge CLK); #1;
        randomize_operands();
        req_valid = 2'b01;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge CLK);
                if (req_ready != 2'b00) seen = 1'b1;
            end
            check("midop_accept", seen, 1'b1);
        end
        @(posedge CLK); #2;
        check("midop_busy", busy, 1'b1);
        nRST = 1'b0; req_valid = 2'b00;
        #1 check_reset_outputs("midop");
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        repeat (5) @(posedge CLK);
        issue(1'b0, ALU_XOR, 32'hdead_beef, 32'h1234_5678);

        // Randomised traffic with random response backpressure.
        for (int i = 0; i < 400; i++) begin
            @(posedge CLK); #1;
            randomize_operands();
            req_valid = req_vec_t'($urandom_range(0, 3));
            rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
        end
        req_valid = 2'b00; rsp_ready = 2'b11;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single ALU between two requesters: req0 (execute stage) and req1 (branch/address unit).
- Grant logic arbitrates between them.
- The winner's operands and aluop are registered and driven to the ALU for one cycle.
- The ALU result and flags are captured and returned to the winner over a valid/ready response handshake.
- One ALU operation is in flight at a time.

Parameters:
MAX_WAIT, 4, consecutive cycles req1 may be valid-and-blocked by req0 before req1 is force-granted (fixed-priority mode only); legal range 1..15.

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous, active-low reset
req_valid  input  2  per-requester request valid (bit i = requester i)
req_ready  output  2  per-requester request accepted this cycle
req_op0, req_op1  input  aluop_t  requested ALU operation
req_a0, req_a1  input  word_t  operand A
req_b0, req_b1  input  word_t  operand B
rsp_valid  output  2  response valid to requester i
rsp_ready  input  2  requester i takes the response
rsp_out  output  word_t  captured ALU result
rsp_flags  output  3  {negative, overflow, zero} captured with the result
alu_op  output  aluop_t  to ALU aluop
alu_a, alu_b  output  word_t  to ALU portA/portB
alu_out  input  word_t  from ALU portOut
alu_zero, alu_overflow, alu_negative  input  1  from ALU flags
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock CLK; reset nRST is asynchronous and active-low.
- Reset values: state=IDLE; req_ready=0; rsp_valid=0; rsp_out=0; rsp_flags=0; alu_op=ALU_ADD; alu_a=0; alu_b=0; owner=0; starve count=0; rr pointer=0; busy=0.
- Asserting nRST mid-operation discards the in-flight op and any pending response; no response is ever produced for it.

State machine (arb_state_t):
- IDLE: req_ready is combinational and one-hot toward the grant winner, gated by state==IDLE.
  - A grant latches owner and registers op, A and B into alu_op/alu_a/alu_b.
  - Next state: EXEC.
  - No valid request: remain in IDLE with req_ready=0.
- EXEC (1 cycle): registered operands drive the ALU.
  - At the clock edge, capture alu_out and the three flags into rsp_out/rsp_flags.
  - Set rsp_valid[owner]=1; next state: RESP.
- RESP: rsp_valid[owner] held high, and rsp_out/rsp_flags held stable, until rsp_ready[owner]=1.
  - Handshake cycle: rsp_valid clears at the next edge; next state: IDLE.
  - The other requester's rsp_ready is ignored.
- Latency: accept at edge N, result captured at edge N+1, rsp_valid high from N+1. Minimum issue interval is 3 cycles.
- After acceptance, req_* inputs may change freely; operands are registered.

Grant (fixed priority, default build):
- req0 wins over req1.
- Starve counter increments each IDLE cycle in which both are valid and req0 is granted. It saturates at MAX_WAIT.
- When count==MAX_WAIT and req1 is valid, req1 is granted and the counter clears.
- A grant to req1 also clears the counter.
- The counter holds outside IDLE.

Boundary rules:
- Both valid, count<MAX_WAIT: req0 wins.
- Single valid: it wins regardless of count.
- Flags are captured unchanged from the ALU; no recomputation.
- alu_out width is exactly word_t; overflow comes from the ALU input only.

Optional Feature:
ALU_ARB_RR_EN:
- Defined: round-robin grant. The 1-bit pointer names the preferred requester and flips to the other index after each grant. The starve counter and MAX_WAIT are not synthesised.
- Undefined: fixed priority with starvation guard, as above.

Decomposition:
- cpu_types_pkg already provides aluop_t and word_t.
- Add to cpu_types_pkg:
  - arb_state_t enum {IDLE, EXEC, RESP}
  - typedef logic [1:0] req_vec_t
  - constant ARB_REQS = 2
- Natural sub-module: alu_arb_grant. It is combinational grant selection from req_valid, rr pointer/starve count and mode, and outputs a one-hot grant. The FSM, registers and ALU hookup remain in alu_arbiter.

Test Plan:
1. Reset then single request: req_valid=01, op=ALU_ADD, A=5, B=7 -> req_ready=01 that cycle; next cycle rsp_valid=01, rsp_out=12, rsp_flags=000; rsp_ready=01 -> IDLE, busy=0.
2. Flags: req1 ALU_SUB A=3 B=3 -> rsp_out=0, zero=1. Then ALU_SUB A=0 B=1 -> rsp_out=0xFFFFFFFF, negative=1. Responses return only on rsp_valid[1].
3. Response backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_out stable all 5 cycles, req_ready=00 throughout, even with both requests valid.
4. Starvation (default build, MAX_WAIT=4): both valid continuously -> grant order req0,req0,req0,req0,req1,req0...
5. Round-robin (ALU_ARB_RR_EN defined): both valid continuously -> grants alternate 0,1,0,1; single valid req1 -> granted every transaction.
6. Reset mid-op: drop nRST during EXEC -> all outputs reset immediately; after release no rsp_valid for the aborted op; next request completes normally.
